multicycle_ctrl: RTL

- FSM controller that sequences the RV32I datapath over multiple cycles: FETCH, DECODE, EXEC, MEM, WB.
- Shares the single unified memory port between instruction fetch and load/store through a req/ready handshake.
- Sits beside the datapath and replaces the single-cycle opcode decoder as the source of the datapath strobes.
- Also counts retired instructions and flags illegal opcodes and memory timeouts.

---
 rtl/rv_ctrl_pkg.sv | 94 +++++++++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// opcode classes and the strobe field encodings seen by the datapath.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_R,
    CL_I,
    CL_L,
    CL_S,
    CL_B,
    CL_JAL,
    CL_JALR,
    CL_SYS,
    CL_ILL
  } op_class_e;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_REL   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_ILLEGAL = 2'b01,
    FLT_TIMEOUT = 2'b10,
    FLT_SYS     = 2'b11
  } fault_e;

  function automatic op_class_e decode_class(input logic [6:0] op);
    op_class_e cls;
    unique case (op)
      OP_R:    cls = CL_R;
      OP_I:    cls = CL_I;
      OP_L:    cls = CL_L;
      OP_S:    cls = CL_S;
      OP_B:    cls = CL_B;
      OP_JAL:  cls = CL_JAL;
      OP_JALR: cls = CL_JALR;
      OP_SYS:  cls = CL_SYS;
      default: cls = CL_ILL;
    endcase
    return cls;
  endfunction

  function automatic aluop_e class_aluop(input op_class_e cls);
    aluop_e op;
    unique case (cls)
      CL_R:    op = ALUOP_R;
      CL_I:    op = ALUOP_I;
      CL_B:    op = ALUOP_BR;
      default: op = ALUOP_ADD;
    endcase
    return op;
  endfunction

  // Operand B is the immediate for address/offset computations and I-type ALU ops.
  function automatic logic class_uses_imm(input op_class_e cls);
    return (cls == CL_I) || (cls == CL_L) || (cls == CL_S) || (cls == CL_JALR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-request cycles; flags expiry on the wait cycle that
// brings the count up to MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int LIMIT = (MEM_TIMEOUT < 1) ? 1 : MEM_TIMEOUT;
  localparam int CW    = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = inc && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (expired) begin
      cnt_d = CW'(LIMIT);
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one
// shared memory port, drives the datapath strobes and counts retirements.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       aluop,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q;
  op_class_e        class_q;
  fault_e           fault_q;
  logic [CNT_W-1:0] retired_q;

  op_class_e dec_class;
  state_e    retire_next;
  logic      retire;
  logic      tmr_inc;
  logic      tmr_clr;
  logic      tmr_expired;

  logic    mem_req_d;
  logic    mem_we_d;
  logic    addr_sel_d;
  logic    ir_write_d;
  logic    pc_write_d;
  logic    alu_src_d;
  logic    reg_write_d;
  pc_src_e pc_src_d;
  aluop_e  aluop_d;
  wb_sel_e wb_sel_d;

  assign dec_class   = decode_class(opcode);
  assign retire_next = run ? ST_FETCH : ST_IDLE;

  // Strobes follow the state and latched class; only the handshake and branch
  // result qualify them within the cycle.
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    addr_sel_d  = 1'b0;
    ir_write_d  = 1'b0;
    pc_write_d  = 1'b0;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    pc_src_d    = PC_PLUS4;
    aluop_d     = ALUOP_ADD;
    wb_sel_d    = WB_ALU;
    unique case (state_q)
      ST_FETCH: begin
        mem_req_d = 1'b1;
        if (mem_ready) begin
          ir_write_d = 1'b1;
          pc_write_d = 1'b1;
        end
      end
      ST_EXEC: begin
        aluop_d   = class_aluop(class_q);
        alu_src_d = class_uses_imm(class_q);
        if ((class_q == CL_B) && branch_taken) begin
          pc_write_d = 1'b1;
          pc_src_d   = PC_REL;
        end
      end
      ST_MEM: begin
        mem_req_d  = 1'b1;
        addr_sel_d = 1'b1;
        mem_we_d   = (class_q == CL_S);
      end
      ST_WB: begin
        reg_write_d = 1'b1;
        unique case (class_q)
          CL_L: wb_sel_d = WB_MEM;
          CL_JAL: begin
            wb_sel_d   = WB_PC4;
            pc_write_d = 1'b1;
            pc_src_d   = PC_REL;
          end
          CL_JALR: begin
            wb_sel_d   = WB_PC4;
            pc_write_d = 1'b1;
            pc_src_d   = PC_ALU;
          end
          default: wb_sel_d = WB_ALU;
        endcase
      end
      default: begin
      end
    endcase
  end

  assign retire = ((state_q == ST_EXEC) && (class_q == CL_B)) ||
                  ((state_q == ST_MEM) && (class_q == CL_S) && mem_ready) ||
                  (state_q == ST_WB);

  assign tmr_inc = mem_req_d && !mem_ready;
  assign tmr_clr = mem_req_d && mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      class_q   <= CL_ILL;
      fault_q   <= FLT_NONE;
      retired_q <= '0;
    end else begin
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            state_q <= ST_DECODE;
          end else if (tmr_expired) begin
            state_q <= ST_HALT;
            fault_q <= FLT_TIMEOUT;
          end
        end
        ST_DECODE: begin
          class_q <= dec_class;
          if (dec_class == CL_SYS) begin
            state_q <= ST_HALT;
            fault_q <= FLT_SYS;
          end else if (dec_class == CL_ILL) begin
            state_q <= ST_HALT;
            fault_q <= FLT_ILLEGAL;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          unique case (class_q)
            CL_B:       state_q <= retire_next;
            CL_L, CL_S: state_q <= ST_MEM;
            default:    state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_q <= (class_q == CL_L) ? ST_WB : retire_next;
          end else if (tmr_expired) begin
            state_q <= ST_HALT;
            fault_q <= FLT_TIMEOUT;
          end
        end
        ST_WB: begin
          state_q <= retire_next;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_d;
  assign mem_we    = mem_we_d;
  assign addr_sel  = addr_sel_d;
  assign ir_write  = ir_write_d;
  assign pc_write  = pc_write_d;
  assign pc_src    = pc_src_d;
  assign alu_src   = alu_src_d;
  assign aluop     = aluop_d;
  assign reg_write = reg_write_d;
  assign wb_sel    = wb_sel_d;
  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule
